// File: rtl/dec_bcd_pkg.sv
// Shared types and helpers for the decimal keypad encoder.
// State enum, digit constants and the priority-encode function.
package dec_bcd_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int BCD_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT,
    HOLD
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] bcd;
    logic             multi;
  } code_t;

  // Highest set index wins; multi flags more than one key.
  function automatic code_t enc_code(
    input logic [NUM_DIGITS-1:0] v
  );
    code_t c;
    int    n;
    c = '0;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) begin
        c.bcd = BCD_W'(i);
        n     = n + 1;
      end
    end
    c.multi = (n > 1);
    return c;
  endfunction

endpackage

// File: rtl/dec_to_bcd_keypad_enc_if.sv
// Valid/ready code channel from the keypad encoder.
// master = encoder side, slave = digit consumer side.
interface dec_to_bcd_keypad_enc_if;
  import dec_bcd_pkg::*;

  logic             valid;
  logic             ready;
  logic [BCD_W-1:0] bcd;
  logic             multi;

  modport master (
    output valid,
    output bcd,
    output multi,
    input  ready
  );

  modport slave (
    input  valid,
    input  bcd,
    input  multi,
    output ready
  );

endinterface

// File: rtl/dec_prio_enc.sv
// Combinational 10-to-4 priority encoder with a multi-key flag.
// Shared by the keypad front ends.
module dec_prio_enc
  import dec_bcd_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] vec,
  output logic [BCD_W-1:0]      bcd,
  output logic                  multi
);

  code_t code;

  // Highest index set in vec, plus popcount > 1.
  always_comb begin
    code  = enc_code(vec);
    bcd   = code.bcd;
    multi = code.multi;
  end

endmodule

// File: rtl/dec_to_bcd_keypad_enc.sv
// Keypad front end: sync, debounce, encode, one code per press.
// Macro KEYPAD_DEBOUNCE_EN builds the SETTLE/HOLD sample counter.
module dec_to_bcd_keypad_enc
  import dec_bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] key,
  dec_to_bcd_keypad_enc_if.master bus,
  output logic                  busy
);

  logic [NUM_DIGITS-1:0] sync1;
  logic [NUM_DIGITS-1:0] s;
  logic [BCD_W-1:0]      enc_bcd;
  logic                  enc_multi;
  logic                  has_key;
  state_t                state;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= key;
      s     <= sync1;
    end
  end

  dec_prio_enc u_enc (
    .vec   (s),
    .bcd   (enc_bcd),
    .multi (enc_multi)
  );

  assign has_key = |s;
  assign busy    = (state != IDLE);

`ifdef KEYPAD_DEBOUNCE_EN

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] cand;
  logic [CW-1:0]         cnt;

  // Press/release qualification FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      bus.valid <= 1'b0;
      bus.bcd   <= '0;
      bus.multi <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && has_key) begin
            cand  <= s;
            cnt   <= CNT_ONE;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!en || !has_key) begin
            state <= IDLE;
          end else if (s == cand) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              bus.bcd   <= enc_bcd;
              bus.multi <= enc_multi;
              bus.valid <= 1'b1;
              state     <= EMIT;
            end
          end else begin
            cand <= s;
            cnt  <= CNT_ONE;
          end
        end
        EMIT: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            cnt       <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (has_key) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 1);

  // Direct-load FSM: first nonzero sample emits a code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.valid <= 1'b0;
      bus.bcd   <= '0;
      bus.multi <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en && has_key) begin
            bus.bcd   <= enc_bcd;
            bus.multi <= enc_multi;
            bus.valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (!has_key) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_dec_to_bcd_keypad_enc.sv
// Bench for dec_to_bcd_keypad_enc with a code scoreboard.
// Timing expectations follow KEYPAD_DEBOUNCE_EN.
module tb_dec_to_bcd_keypad_enc;

  localparam int N = 4;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int LAT    = N + 2;
  localparam int EN_LAT = N;
  localparam int BP_REL = N;
`else
  localparam int LAT    = 3;
  localparam int EN_LAT = 1;
  localparam int BP_REL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] key;
  logic       busy;

  dec_to_bcd_keypad_enc_if bus ();

  dec_to_bcd_keypad_enc #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .key  (key),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int xfers  = 0;
  int pushes = 0;
  logic [4:0] sbq[$];
  logic [4:0] exp_code;

  task automatic chk(string tag, int got, int want);
    n_chk = n_chk + 1;
    if (got == want) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, want %0d",
                  tag, got, want);
  endtask

  function automatic logic [4:0] ref_code(
    input logic [9:0] v
  );
    int   hi;
    logic found;
    hi    = 0;
    found = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (v[i] && !found) begin
        hi    = i;
        found = 1'b1;
      end
    end
    return {4'(hi), ($countones(v) > 1)};
  endfunction

  task automatic push(input logic [9:0] v);
    sbq.push_back(ref_code(v));
    pushes = pushes + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    do begin
      step();
      e = e + 1;
    end while (!bus.valid && e < 60);
  endtask

  task automatic wait_idle(output int e);
    e = 0;
    while (busy && e < 60) begin
      step();
      e = e + 1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid && bus.ready) begin
      if (sbq.size() == 0) begin
        chk("sb_extra", sbq.size(), 1);
      end else begin
        exp_code = sbq.pop_front();
        chk("sb_bcd", int'(bus.bcd), int'(exp_code[4:1]));
        chk("sb_multi", int'(bus.multi), int'(exp_code[0]));
        xfers = xfers + 1;
      end
    end
  end

  logic [9:0] pats[4] = '{10'h001, 10'h3FF,
                          10'h003, 10'h040};

  initial begin
    int   e;
    logic any_v;
    logic any_b;
    logic ok;

    rst       = 1'b1;
    en        = 1'b0;
    key       = '0;
    bus.ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bcd", int'(bus.bcd), 0);
    chk("rst_multi", int'(bus.multi), 0);
    rst       = 1'b0;
    en        = 1'b1;
    bus.ready = 1'b1;
    repeat (2) step();

    // basic press
    push(10'h020);
    key = 10'h020;
    wait_valid(e);
    chk("s1_lat", e, LAT);
    repeat (20 - LAT) step();
    key = '0;
    wait_idle(e);
    chk("s1_rel", e, LAT);
    chk("s1_xfers", xfers, 1);

    // two keys
    push(10'b10_0000_1000);
    key = 10'b10_0000_1000;
    wait_valid(e);
    chk("s2_lat", e, LAT);
    repeat (3) step();
    key = '0;
    wait_idle(e);
    chk("s2_rel", e, LAT);

`ifdef KEYPAD_DEBOUNCE_EN
    // bounce on key 7
    any_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key = (i % 2 == 0) ? 10'h080 : 10'h000;
      repeat (2) begin
        step();
        any_v = any_v | bus.valid;
      end
    end
    chk("s3_novalid", int'(any_v), 0);
    push(10'h080);
    key = 10'h080;
    wait_valid(e);
    chk("s3_lat", e, LAT);
    repeat (2) step();
    key = '0;
    wait_idle(e);
    chk("s3_rel", e, LAT);
`endif

    // backpressure
    bus.ready = 1'b0;
    push(10'h008);
    key = 10'h008;
    wait_valid(e);
    chk("s4_lat", e, LAT);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) key = '0;
      step();
      ok = ok & bus.valid & (bus.bcd == 4'd3);
    end
    chk("s4_stable", int'(ok), 1);
    bus.ready = 1'b1;
    step();
    chk("s4_vfall", int'(bus.valid), 0);
    wait_idle(e);
    chk("s4_rel", e, BP_REL);

    // enable low blocks presses
    en    = 1'b0;
    key   = 10'h004;
    any_v = 1'b0;
    any_b = 1'b0;
    repeat (30) begin
      step();
      any_v = any_v | bus.valid;
      any_b = any_b | busy;
    end
    chk("s5_novalid", int'(any_v), 0);
    chk("s5_nobusy", int'(any_b), 0);
    push(10'h004);
    en = 1'b1;
    wait_valid(e);
    chk("s5_lat", e, EN_LAT);
    repeat (2) step();
    key = '0;
    wait_idle(e);
    chk("s5_rel", e, LAT);

    // reset while a code is pending
    bus.ready = 1'b0;
    key       = 10'h100;
    wait_valid(e);
    chk("s6_lat0", e, LAT);
    rst = 1'b1;
    step();
    chk("s6_valid", int'(bus.valid), 0);
    chk("s6_busy", int'(busy), 0);
    rst       = 1'b0;
    bus.ready = 1'b1;
    push(10'h100);
    wait_valid(e);
    chk("s6_lat", e, LAT);
    repeat (2) step();
    key = '0;
    wait_idle(e);
    chk("s6_rel", e, LAT);

    // pattern table: key 0, all keys, low pair, single
    for (int p = 0; p < 4; p++) begin
      push(pats[p]);
      key = pats[p];
      wait_valid(e);
      chk("s7_lat", e, LAT);
      repeat (2) step();
      key = '0;
      wait_idle(e);
      chk("s7_rel", e, LAT);
    end

    repeat (4) step();
    chk("sb_left", sbq.size(), 0);
    chk("xfers", xfers, pushes);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
